// File: rtl/seg_scan_decoder.sv
// Readback decoder for the 6-digit multiplexed seven-segment scan bus: rebuilds
// each digit, sign and dot mask, then converts the BCD frame to a binary value.
module seg_scan_decoder #(
    parameter int SAMPLE_DLY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  sel,
    input  logic [7:0]  seg,
    output logic [19:0] data,
    output logic        sign,
    output logic [5:0]  point,
    output logic        valid,
    output logic        err
);
    localparam logic [3:0] C_SIGN    = 4'd10;
    localparam logic [3:0] C_BLANK   = 4'd11;
    localparam logic [3:0] C_ILL     = 4'd15;
    localparam logic [7:0] SAMPLE_AT = 8'(SAMPLE_DLY - 1);
    localparam logic [4:0] LAST_ITER = 5'd19;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONV,
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state, w_state_next;
    logic [5:0]  r_sel_prev;
    logic [7:0]  r_cnt, w_cnt;
    logic        w_sample, w_onehot, w_store, w_complete, w_frame_ok;
    logic [3:0]  w_code;
    logic [5:0]  r_mask, w_mask_next;
    logic        r_ferr, w_ferr_next;
    logic [3:0]  r_code [6];
    logic [5:0]  r_dot;
    logic [3:0]  w_codes_next [6];
    logic [23:0] w_bcd;
    logic        w_sign_ld;
    logic [5:0]  w_point_ld;
    logic [43:0] r_shift, w_shift_step;
    logic [4:0]  r_iter;
    logic        r_sign_ld;
    logic [5:0]  r_point_ld;

    // Count of cycles the current sel value has been stable, as seen this cycle.
    assign w_cnt    = (sel != r_sel_prev) ? 8'd0 :
                      ((r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1);
    assign w_sample = (w_cnt == SAMPLE_AT);
    assign w_onehot = (sel != 6'd0) && ((sel & (sel - 6'd1)) == 6'd0);
    assign w_store  = w_sample && w_onehot;

    always_comb begin
        case (seg[6:0])
            7'b1000000: w_code = 4'd0;
            7'b1111001: w_code = 4'd1;
            7'b0100100: w_code = 4'd2;
            7'b0110000: w_code = 4'd3;
            7'b0011001: w_code = 4'd4;
            7'b0010010: w_code = 4'd5;
            7'b0000010: w_code = 4'd6;
            7'b1111000: w_code = 4'd7;
            7'b0000000: w_code = 4'd8;
            7'b0010000: w_code = 4'd9;
            7'b0111111: w_code = C_SIGN;
            7'b1111111: w_code = C_BLANK;
            default:    w_code = C_ILL;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            w_codes_next[i] = (w_store && sel[i]) ? w_code : r_code[i];
        end
    end

    assign w_mask_next = r_mask | (w_store ? sel : 6'd0);
    assign w_ferr_next = r_ferr | (w_sample && (sel != 6'd0) && !w_onehot)
                                | (w_store && (w_code == C_ILL));
    assign w_complete  = w_store && (w_mask_next == 6'h3F);

    // Walking up from digit 0: numerics, then at most one sign, then blanks only.
    always_comb begin
        logic seen_non_num;
        seen_non_num = 1'b0;
        w_frame_ok   = (w_codes_next[0] <= 4'd9) && !w_ferr_next;
        for (int i = 0; i < 6; i++) begin
            if (w_codes_next[i] <= 4'd9) begin
                if (seen_non_num) w_frame_ok = 1'b0;
            end else if (w_codes_next[i] == C_SIGN) begin
                if (seen_non_num) w_frame_ok = 1'b0;
                seen_non_num = 1'b1;
            end else if (w_codes_next[i] == C_BLANK) begin
                seen_non_num = 1'b1;
            end else begin
                w_frame_ok = 1'b0;
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sel_prev <= 6'd0;
            r_cnt      <= 8'd0;
            r_mask     <= 6'd0;
            r_ferr     <= 1'b0;
        end else begin
            r_sel_prev <= sel;
            r_cnt      <= w_cnt;
            if (w_complete || (w_sample && (sel == 6'd0))) begin
                r_mask <= 6'd0;
                r_ferr <= 1'b0;
            end else begin
                r_mask <= w_mask_next;
                r_ferr <= w_ferr_next;
            end
        end
    end

    // NOTE: digit slots carry no reset; the capture mask alone says which are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (w_store && sel[i]) begin
                r_code[i] <= w_code;
                r_dot[i]  <= seg[7];
            end
        end
    end

    // NOTE: next state defaults to the current one first, so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_complete) w_state_next = w_frame_ok ? S_LOAD : S_ERR;
            S_LOAD:  w_state_next = S_CONV;
            S_CONV:  if (r_iter == LAST_ITER) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_bcd      = 24'd0;
        w_sign_ld  = 1'b0;
        w_point_ld = 6'd0;
        for (int i = 0; i < 6; i++) begin
            if (r_code[i] <= 4'd9) begin
                w_bcd[4*i +: 4] = r_code[i];
                w_point_ld[i]   = r_dot[i];
            end else if (r_code[i] == C_SIGN) begin
                w_sign_ld = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift right, then pull nibbles >= 8 down by 3.
    always_comb begin
        w_shift_step = r_shift >> 1;
        for (int n = 0; n < 6; n++) begin
            if (w_shift_step[20 + 4*n +: 4] >= 4'd8)
                w_shift_step[20 + 4*n +: 4] = w_shift_step[20 + 4*n +: 4] - 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_shift    <= 44'd0;
            r_iter     <= 5'd0;
            r_sign_ld  <= 1'b0;
            r_point_ld <= 6'd0;
            data       <= 20'd0;
            sign       <= 1'b0;
            point      <= 6'd0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_shift    <= {w_bcd, 20'd0};
                    r_iter     <= 5'd0;
                    r_sign_ld  <= w_sign_ld;
                    r_point_ld <= w_point_ld;
                end
                S_CONV: begin
                    r_shift <= w_shift_step;
                    r_iter  <= r_iter + 5'd1;
                    if (r_iter == LAST_ITER) begin
                        data  <= w_shift_step[19:0];
                        sign  <= r_sign_ld;
                        point <= r_point_ld;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (r_state == S_DONE);
    assign err   = (r_state == S_ERR);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed display frames plus random
// scans, compared every cycle against a frame-level model of the readback rules.
module tb_seg_scan_decoder;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic [19:0] data;
    logic        sign;
    logic [5:0]  point;
    logic        valid;
    logic        err;

    seg_scan_decoder #(.SAMPLE_DLY(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .seg   (seg),
        .data  (data),
        .sign  (sign),
        .point (point),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Codes: 0..9 digits, 10 sign, 11 blank, 12 an illegal pattern.
    function automatic logic [6:0] pat(input int d);
        case (d)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0111111;
            11: return 7'b1111111;
            default: return 7'b1010101;
        endcase
    endfunction

    function automatic int decode(input logic [6:0] p);
        for (int d = 0; d < 12; d++) if (pat(d) == p) return d;
        return 12;
    endfunction

    // Digits 0..k-1 numeric, optional sign at k, blanks above; value is plain decimal.
    function automatic void eval_frame(input int codes[6], input logic [5:0] dots,
                                       output bit ok, output int value,
                                       output bit neg, output logic [5:0] pts);
        int k;
        int w;
        k = 0;
        while (k < 6 && codes[k] <= 9) k++;
        ok = (k >= 1);
        neg = 1'b0;
        value = 0;
        pts = 6'd0;
        w = 1;
        for (int i = 0; i < k; i++) begin
            value += codes[i] * w;
            w *= 10;
            pts[i] = dots[i];
        end
        if (k < 6 && codes[k] == 10) begin
            neg = 1'b1;
            for (int i = k + 1; i < 6; i++) if (codes[i] != 11) ok = 1'b0;
        end else begin
            for (int i = k; i < 6; i++) if (codes[i] != 11) ok = 1'b0;
        end
    endfunction

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    int          start_cyc = 0;
    int          idle_from = 0;
    logic [5:0]  m_prev = 6'd0;
    logic [5:0]  m_mask = 6'd0;
    bit          m_ferr = 1'b0;
    int          m_code [6];
    logic [5:0]  m_dot = 6'd0;
    int          pend_v = -1;
    int          pend_e = -1;
    logic [19:0] pend_data;
    logic        pend_sign;
    logic [5:0]  pend_point;
    logic [19:0] h_data = 20'd0;
    logic        h_sign = 1'b0;
    logic [5:0]  h_point = 6'd0;
    bit          chk_en = 1'b0;

    initial begin
        bit          ok;
        int          value;
        bit          neg;
        logic [5:0]  pts;
        int          idx;
        forever begin
            @(posedge clk);
            if (rst_n === 1'b1) begin
                start_cyc = cyc;
                m_prev = 6'd0;
                m_mask = 6'd0;
                m_ferr = 1'b0;
                idle_from = cyc + 1;
                pend_v = -1;
                pend_e = -1;
                h_data = 20'd0;
                h_sign = 1'b0;
                h_point = 6'd0;
            end else begin
                if (sel !== m_prev) begin
                    m_prev = sel;
                    start_cyc = cyc;
                end
                if (cyc - start_cyc == D - 1) begin
                    if (sel == 6'd0) begin
                        m_mask = 6'd0;
                        m_ferr = 1'b0;
                    end else if ($countones(sel) != 1) begin
                        m_ferr = 1'b1;
                    end else begin
                        idx = 0;
                        for (int i = 0; i < 6; i++) if (sel[i]) idx = i;
                        m_code[idx] = decode(seg[6:0]);
                        m_dot[idx]  = seg[7];
                        m_mask[idx] = 1'b1;
                        if (m_code[idx] == 12) m_ferr = 1'b1;
                        if (m_mask == 6'h3F) begin
                            if (cyc >= idle_from) begin
                                eval_frame(m_code, m_dot, ok, value, neg, pts);
                                if (ok && !m_ferr) begin
                                    pend_v = cyc + 22;
                                    pend_data = 20'(value);
                                    pend_sign = neg;
                                    pend_point = pts;
                                    idle_from = cyc + 23;
                                end else begin
                                    pend_e = cyc + 1;
                                    idle_from = cyc + 2;
                                end
                            end
                            m_mask = 6'd0;
                            m_ferr = 1'b0;
                        end
                    end
                end
            end
            cyc++;
        end
    end

    // Compare process: every cycle after reset, DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (cyc == pend_v) begin
                    h_data = pend_data;
                    h_sign = pend_sign;
                    h_point = pend_point;
                end
                check("valid", valid, (cyc == pend_v));
                check("err", err, (cyc == pend_e));
                check("data", data, h_data);
                check("sign", sign, h_sign);
                check("point", point, h_point);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int d, input logic [7:0] s, input int dwell, input int skew);
        sel = 6'b1 << d;
        if (skew > 0) tick(skew);
        seg = s;
        tick(dwell - skew);
    endtask

    // Digits 0..4 with full dwell; digit 5 is left selected for the caller to time.
    task automatic scan(input int f[6], input logic [5:0] dots, input int dwell, input int skew);
        for (int d = 0; d < 5; d++) show(d, {dots[d], pat(f[d])}, dwell, skew);
        sel = 6'b100000;
        if (skew > 0) tick(skew);
        seg = {dots[5], pat(f[5])};
    endtask

    task automatic wait_pulse(input bit want_err, output int k);
        k = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if ((want_err ? err : valid) === 1'b1) begin
                k = n;
                break;
            end
        end
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid === 1'b1) cnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f[6];
        int k;
        int cnt;
        logic [5:0] dots;
        int dw;

        rst_n = 1'b1;
        sel = 6'd0;
        seg = 8'hFF;
        tick(3);
        rst_n = 1'b0;
        chk_en = 1'b1;
        check("rst_data", data, 20'd0);
        check("rst_sign", sign, 1'b0);
        check("rst_point", point, 6'd0);
        check("rst_valid", valid, 1'b0);
        check("rst_err", err, 1'b0);
        tick(5);

        // 123456 with dot on digit 2
        f = '{6, 5, 4, 3, 2, 1};
        scan(f, 6'b000100, 6, 0);
        wait_pulse(1'b0, k);
        check("pos_latency", k, 25);
        check("pos_data", data, 20'h1E240);
        check("pos_model", h_data, 20'h1E240);
        check("pos_sign", sign, 1'b0);
        check("pos_point", point, 6'b000100);
        tick(5);

        // illegal pattern on digit 2: err at T+1, data holds
        f = '{6, 5, 12, 3, 2, 1};
        scan(f, 6'b000000, 6, 0);
        wait_pulse(1'b1, k);
        check("ill_latency", k, 4);
        count_valid(25, cnt);
        check("ill_no_valid", cnt, 0);
        check("ill_hold", data, 20'h1E240);

        // -42 with dots on a blank and the sign position
        f = '{2, 4, 10, 11, 11, 11};
        scan(f, 6'b010100, 5, 0);
        wait_pulse(1'b0, k);
        check("neg_latency", k, 25);
        check("neg_data", data, 20'd42);
        check("neg_sign", sign, 1'b1);
        check("neg_point", point, 6'b000000);
        tick(3);

        // all blank, digit 0 = 0
        f = '{0, 11, 11, 11, 11, 11};
        scan(f, 6'b000000, 4, 0);
        wait_pulse(1'b0, k);
        check("zero_latency", k, 25);
        check("zero_data", data, 20'd0);
        check("zero_sign", sign, 1'b0);
        tick(3);

        // 999999
        f = '{9, 9, 9, 9, 9, 9};
        scan(f, 6'b100001, 6, 0);
        wait_pulse(1'b0, k);
        check("max_data", data, 20'hF423F);
        check("max_model", h_data, 20'hF423F);
        check("max_point", point, 6'b100001);
        tick(3);

        // non-one-hot select in the middle of a frame
        show(0, {1'b0, pat(1)}, 6, 0);
        show(1, {1'b0, pat(2)}, 6, 0);
        sel = 6'b000011;
        tick(6);
        for (int d = 2; d < 5; d++) show(d, {1'b0, pat(3)}, 6, 0);
        sel = 6'b100000;
        seg = {1'b0, pat(4)};
        wait_pulse(1'b1, k);
        check("sel2_err_latency", k, 4);
        check("sel2_hold", data, 20'hF423F);
        tick(3);

        // sel=0 dwell clears a partial, erroneous frame
        show(0, {1'b0, pat(5)}, 6, 0);
        show(1, {1'b0, pat(12)}, 6, 0);
        show(2, {1'b0, pat(7)}, 6, 0);
        sel = 6'd0;
        tick(6);
        f = '{1, 2, 3, 4, 5, 6};
        scan(f, 6'b000000, 6, 0);
        wait_pulse(1'b0, k);
        check("sel0_latency", k, 25);
        check("sel0_data", data, 20'h9FBF1);
        tick(3);

        // short dwell on digit 3 is not sampled; a later full dwell completes the frame
        for (int d = 0; d < 3; d++) show(d, {1'b0, pat(d == 0 ? 7 : (d == 1 ? 0 : 8))}, 5, 0);
        show(3, {1'b0, pat(12)}, 3, 0);
        show(4, {1'b0, pat(0)}, 5, 0);
        show(5, {1'b0, pat(5)}, 5, 0);
        sel = 6'b001000;
        seg = {1'b0, pat(3)};
        wait_pulse(1'b0, k);
        check("short_latency", k, 25);
        check("short_data", data, 20'h7AFFF);
        tick(3);

        // seg lagging sel by two cycles
        f = '{0, 5, 6, 7, 8, 9};
        scan(f, 6'b000010, 6, 2);
        wait_pulse(1'b0, k);
        check("skew_latency", k, 23);
        check("skew_data", data, 20'hF1202);
        check("skew_point", point, 6'b000010);
        tick(3);

        // reset at T+10 of a conversion
        f = '{1, 1, 1, 1, 1, 1};
        scan(f, 6'b000000, 6, 0);
        tick(13);
        rst_n = 1'b1;
        tick(1);
        rst_n = 1'b0;
        check("rstc_data", data, 20'd0);
        check("rstc_sign", sign, 1'b0);
        check("rstc_point", point, 6'd0);
        count_valid(30, cnt);
        check("rstc_no_valid", cnt, 0);

        // random scans
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(1, 6);
            for (int i = 0; i < 6; i++) f[i] = 11;
            for (int i = 0; i < k; i++) f[i] = $urandom_range(0, 9);
            if (k < 6 && $urandom_range(0, 1) == 1) f[k] = 10;
            if ($urandom_range(0, 4) == 0) f[$urandom_range(0, 5)] = $urandom_range(0, 12);
            dots = 6'($urandom);
            for (int d = 0; d < 6; d++) begin
                if ($urandom_range(0, 11) == 0) begin
                    sel = ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(3, 63));
                    tick($urandom_range(2, 6));
                end
                dw = $urandom_range(2, 7);
                show(d, {dots[d], pat(f[d])}, dw, $urandom_range(0, 1));
            end
            tick($urandom_range(0, 30));
        end
        tick(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
